// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared size encodings and helpers for the 64-bit data memory
// Purpose: access-size encodings and the size-to-byte-count mapping used by
//          the memory top and its bench.
// Ports:   none (package).
package ram_pkg;

   localparam logic [1:0] SIZE_8  = 2'b00;
   localparam logic [1:0] SIZE_16 = 2'b01;
   localparam logic [1:0] SIZE_32 = 2'b10;
   localparam logic [1:0] SIZE_64 = 2'b11;

   function automatic logic [3:0] size_to_bytes(input logic [1:0] size);
      case (size)
         SIZE_8:  return 4'd1;
         SIZE_16: return 4'd2;
         SIZE_32: return 4'd4;
         default: return 4'd8;
      endcase
   endfunction

endpackage

// File: rtl/ram_8bit_bank.sv
// rtl/ram_8bit_bank.sv - one byte-wide storage bank (one byte lane)
// Purpose: byte-wide memory with a synchronous write and a combinational
//          read; the top registers the assembled read data.
// Ports:   clock        in   system clock
//          address      in   WORD_AW  word index within the bank
//          data_in      in   8        byte to store
//          write_enable in   1        write strobe for this lane
//          data_out     out  8        byte at address
module ram_8bit_bank #(
   parameter int WORD_AW = 13
) (
   input  logic               clock,
   input  logic [WORD_AW-1:0] address,
   input  logic [7:0]         data_in,
   input  logic               write_enable,
   output logic [7:0]         data_out
);

   logic [7:0] mem [0:(2**WORD_AW)-1];

   always_ff @(posedge clock) begin
      if (write_enable) begin
         mem[address] <= data_in;
      end
   end

   assign data_out = mem[address];

endmodule

// File: rtl/ram_64bit.sv
// rtl/ram_64bit.sv - byte-addressable 64-bit data memory with unaligned access
// Purpose: 8/16/32/64-bit little-endian reads and writes at any byte address,
//          including accesses straddling a word boundary, over one
//          bidirectional bus. Eight byte banks, one per lane.
// Ports:   clock         in     system clock
//          reset         in     synchronous active-high reset
//          address       in     ADDR_WIDTH  byte address of the LS byte
//          data          inout  64          LSB-aligned data bus
//          chip_select   in     1           block enable
//          write_enable  in     1           write request (wins over read)
//          output_enable in     1           read request / bus drive enable
//          size          in     2           00=8, 01=16, 10=32, 11=64 bit
// Macro:   RAM_64BIT_SIGN_EXT_EN - sign-extend 8/16/32-bit reads
module ram_64bit
   import ram_pkg::*;
#(
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] address,
   inout  wire  [63:0]           data,
   input  logic                  chip_select,
   input  logic                  write_enable,
   input  logic                  output_enable,
   input  logic [1:0]            size
);

   localparam int WAW = ADDR_WIDTH - 3;

`ifdef RAM_64BIT_SIGN_EXT_EN
   localparam logic SIGN_EXT = 1'b1;
`else
   localparam logic SIGN_EXT = 1'b0;
`endif

   logic [2:0]     w_off;
   logic [WAW-1:0] w_word;
   logic [WAW-1:0] w_word_next;
   logic [3:0]     w_nbytes;
   logic [6:0]     w_shift;
   logic [7:0]     cs;
   logic [7:0]     a_select;
   logic [7:0]     w_we;
   logic [WAW-1:0] w_lane_addr [8];
   logic [63:0]    ram_in;
   logic [63:0]    w_lane_vec;
   logic [63:0]    w_rot;
   logic [63:0]    w_rd;
   logic [63:0]    r_rdata;
   logic           w_drive;

   assign w_off       = address[2:0];
   assign w_word      = address[ADDR_WIDTH-1:3];
   assign w_word_next = w_word + 1'b1;    // wraps to word 0 at the top
   assign w_nbytes    = size_to_bytes(size);
   assign w_shift     = {1'b0, w_off, 3'b000};

   // Lanes below the offset hold the bytes that spill into the next word.
   always_comb begin
      a_select = '0;
      cs       = '0;
      for (int i = 0; i < 8; i++) begin
         a_select[i]    = 3'(i) < w_off;
         w_lane_addr[i] = a_select[i] ? w_word_next : w_word;
         cs[i]          = chip_select & ({1'b0, 3'(3'(i) - w_off)} < w_nbytes);
      end
   end

   assign w_we   = cs & {8{write_enable & ~reset}};

   // Rotate left so value byte k lands on lane (off+k) mod 8.
   assign ram_in = (data << w_shift) | (data >> (7'd64 - w_shift));

   ram_8bit_bank #(.WORD_AW(WAW)) ram0 (.clock(clock), .address(w_lane_addr[0]), .data_in(ram_in[7:0]),   .write_enable(w_we[0]), .data_out(w_lane_vec[7:0]));
   ram_8bit_bank #(.WORD_AW(WAW)) ram1 (.clock(clock), .address(w_lane_addr[1]), .data_in(ram_in[15:8]),  .write_enable(w_we[1]), .data_out(w_lane_vec[15:8]));
   ram_8bit_bank #(.WORD_AW(WAW)) ram2 (.clock(clock), .address(w_lane_addr[2]), .data_in(ram_in[23:16]), .write_enable(w_we[2]), .data_out(w_lane_vec[23:16]));
   ram_8bit_bank #(.WORD_AW(WAW)) ram3 (.clock(clock), .address(w_lane_addr[3]), .data_in(ram_in[31:24]), .write_enable(w_we[3]), .data_out(w_lane_vec[31:24]));
   ram_8bit_bank #(.WORD_AW(WAW)) ram4 (.clock(clock), .address(w_lane_addr[4]), .data_in(ram_in[39:32]), .write_enable(w_we[4]), .data_out(w_lane_vec[39:32]));
   ram_8bit_bank #(.WORD_AW(WAW)) ram5 (.clock(clock), .address(w_lane_addr[5]), .data_in(ram_in[47:40]), .write_enable(w_we[5]), .data_out(w_lane_vec[47:40]));
   ram_8bit_bank #(.WORD_AW(WAW)) ram6 (.clock(clock), .address(w_lane_addr[6]), .data_in(ram_in[55:48]), .write_enable(w_we[6]), .data_out(w_lane_vec[55:48]));
   ram_8bit_bank #(.WORD_AW(WAW)) ram7 (.clock(clock), .address(w_lane_addr[7]), .data_in(ram_in[63:56]), .write_enable(w_we[7]), .data_out(w_lane_vec[63:56]));

   // Undo the lane rotation, then trim/extend to the access width.
   assign w_rot = (w_lane_vec >> w_shift) | (w_lane_vec << (7'd64 - w_shift));

   always_comb begin
      w_rd = w_rot;
      case (size)
         SIZE_8:  w_rd = {{56{SIGN_EXT & w_rot[7]}},  w_rot[7:0]};
         SIZE_16: w_rd = {{48{SIGN_EXT & w_rot[15]}}, w_rot[15:0]};
         SIZE_32: w_rd = {{32{SIGN_EXT & w_rot[31]}}, w_rot[31:0]};
         default: w_rd = w_rot;
      endcase
   end

   assign w_drive = chip_select & output_enable & ~write_enable;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_rdata <= '0;
      end else if (w_drive) begin
         r_rdata <= w_rd;
      end
   end

   assign data = w_drive ? r_rdata : 64'bz;

endmodule

// File: tb/tb_ram_64bit.sv
// tb/tb_ram_64bit.sv - scoreboard bench for the byte-addressable 64-bit memory
module tb_ram_64bit;

   logic        clock = 1'b0;
   logic        reset;
   logic [11:0] address;
   wire  [63:0] data;
   logic        chip_select;
   logic        write_enable;
   logic        output_enable;
   logic [1:0]  size;
   logic        tb_en;
   logic [63:0] tb_data;
   logic        mon_v;

   typedef struct packed {
      logic [7:0]  id;
      logic [63:0] val;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   n_pass  = 0;
   int   n_total = 0;

   assign data = tb_en ? tb_data : 64'bz;

   always #5 clock = ~clock;

   ram_64bit #(.ADDR_WIDTH(12)) dut (
      .clock(clock),
      .reset(reset),
      .address(address),
      .data(data),
      .chip_select(chip_select),
      .write_enable(write_enable),
      .output_enable(output_enable),
      .size(size)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   function automatic logic [63:0] ext(input logic [63:0] v, input logic [1:0] sz);
      logic s;
`ifdef RAM_64BIT_SIGN_EXT_EN
      s = 1'b1;
`else
      s = 1'b0;
`endif
      case (sz)
         2'd0:    return {{56{s & v[7]}},  v[7:0]};
         2'd1:    return {{48{s & v[15]}}, v[15:0]};
         2'd2:    return {{32{s & v[31]}}, v[31:0]};
         default: return v;
      endcase
   endfunction

   task automatic idle();
      @(negedge clock);
      chip_select = 0; write_enable = 0; output_enable = 0; tb_en = 0;
   endtask

   task automatic wr(input logic [11:0] a, input logic [1:0] sz, input logic [63:0] v);
      @(negedge clock);
      address = a; size = sz; tb_data = v; tb_en = 1;
      chip_select = 1; write_enable = 1; output_enable = 0;
   endtask

   task automatic rd(input logic [7:0] id, input logic [11:0] a, input logic [1:0] sz, input logic [63:0] v);
      @(negedge clock);
      address = a; size = sz; tb_en = 0;
      chip_select = 1; write_enable = 0; output_enable = 1;
      exp_q.push_back({id, v});
   endtask

   // Monitor: a read accepted on an edge presents its data on the bus just after it.
   initial begin
      forever begin
         @(posedge clock);
         mon_v = chip_select & output_enable & ~write_enable & ~reset;
         #2;
         if (mon_v) begin
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_read: got %h, expected no read", data);
            end else begin
               e = exp_q.pop_front();
               check($sformatf("read_%0d", e.id), data, e.val);
            end
         end
      end
   end

   initial begin
      reset = 1; chip_select = 0; write_enable = 0; output_enable = 0;
      size = 0; address = 0; tb_en = 0; tb_data = 0;
      repeat (2) @(posedge clock);
      #1;
      check("reset_rdata", dut.r_rdata, 64'h0);
      check("reset_no_drive", {63'd0, dut.w_drive}, 64'd0);
      @(negedge clock); reset = 0;

      // aligned 64-bit write into word 1
      wr(12'd8, 2'd3, 64'h0706050403020100);
      #1;
      check("w8_cs", {56'd0, dut.cs}, 64'hFF);
      check("w8_asel", {56'd0, dut.a_select}, 64'h00);
      check("oe_low_no_drive", {63'd0, dut.w_drive}, 64'd0);
      idle();
      check("word1", {dut.ram7.mem[1], dut.ram6.mem[1], dut.ram5.mem[1], dut.ram4.mem[1],
                      dut.ram3.mem[1], dut.ram2.mem[1], dut.ram1.mem[1], dut.ram0.mem[1]},
            64'h0706050403020100);

      // build word 2 from unaligned partial writes
      wr(12'd23, 2'd0, 64'h0F);
      wr(12'd21, 2'd1, 64'h0E0D);
      wr(12'd17, 2'd2, 64'h0C0B0A09);
      #1;
      check("w17_cs", {56'd0, dut.cs}, 64'h1E);
      check("w17_ram_in", dut.ram_in, 64'h0000000C0B0A0900);
      wr(12'd16, 2'd0, 64'h08);
      idle();
      check("word2", {dut.ram7.mem[2], dut.ram6.mem[2], dut.ram5.mem[2], dut.ram4.mem[2],
                      dut.ram3.mem[2], dut.ram2.mem[2], dut.ram1.mem[2], dut.ram0.mem[2]},
            64'h0F0E0D0C0B0A0908);

      // straddling reads
      rd(8'd1, 12'd9,  2'd0, 64'h01);
      #1;
      check("read_drives_bus", {63'd0, dut.w_drive}, 64'd1);
      rd(8'd2, 12'd15, 2'd1, 64'h0807);
      rd(8'd3, 12'd13, 2'd2, 64'h08070605);
      rd(8'd4, 12'd12, 2'd3, 64'h0B0A090807060504);
      #1;
      check("r12_asel", {56'd0, dut.a_select}, 64'h0F);

      // write and read both requested: write wins, bus not driven
      @(negedge clock);
      address = 12'd24; size = 2'd0; tb_data = 64'hAA; tb_en = 1;
      chip_select = 1; write_enable = 1; output_enable = 1;
      #1;
      check("prio_no_drive", {63'd0, dut.w_drive}, 64'd0);
      rd(8'd5, 12'd24, 2'd0, ext(64'hAA, 2'd0));

      // reset clears the read register; writes during reset are dropped
      rd(8'd6, 12'd8, 2'd3, 64'h0706050403020100);
      @(negedge clock); reset = 1;
      @(posedge clock); #3;
      check("reset_clears_rdata", dut.r_rdata, 64'h0);
      check("reset_bus_zero", data, 64'h0);
      wr(12'd8, 2'd3, 64'hDEADBEEFCAFEF00D);
      @(negedge clock); reset = 0; chip_select = 0; write_enable = 0; tb_en = 0;
      rd(8'd7, 12'd8, 2'd3, 64'h0706050403020100);

      // wrap past the top address into word 0
      wr(12'd4092, 2'd3, 64'h1122334455667788);
      idle();
      check("wrap_hi", {dut.ram7.mem[511], dut.ram6.mem[511], dut.ram5.mem[511], dut.ram4.mem[511]},
            64'h55667788);
      check("wrap_lo", {dut.ram3.mem[0], dut.ram2.mem[0], dut.ram1.mem[0], dut.ram0.mem[0]},
            64'h11223344);
      rd(8'd8, 12'd4092, 2'd3, 64'h1122334455667788);
      rd(8'd9, 12'd4092, 2'd0, ext(64'h88, 2'd0));
      rd(8'd10, 12'd4094, 2'd1, ext(64'h5566, 2'd1));
      idle();
      idle();
      check("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
